instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Instruction source for the 8-bit CPU core (`main`); it is the producer end of the instruction stream that `main` consumes on IN0.
- Holds a loadable program memory and a program counter, and issues one instruction at a time over a valid/ready handshake.
- Resolves condition-class instructions (opcode 2'b11) against CPU register values supplied by the core, then redirects the PC on a taken branch.
- Sits between the board-level program loader and `main`.

Parameters:
- ADDR_W, 8, program counter and memory address width; memory depth is 2**ADDR_W words.
- DATA_W, 8, instruction width; it must equal the CPU's IN0 width.
- CNT_W, 16, width of the issued-instruction counter.

Ports:
- clk  input  1  sole clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- load_en  input  1  program-memory write strobe; honoured only in IDLE or HALT.
- load_addr  input  ADDR_W  program-memory write address.
- load_data  input  DATA_W  program-memory write data.
- prog_len  input  ADDR_W+1  number of valid program words; sampled when run is accepted.
- run  input  1  start pulse; honoured only in IDLE or HALT.
- instr_out  output  DATA_W  instruction presented to the CPU.
- instr_valid  output  1  instr_out holds a valid instruction.
- instr_ready  input  1  CPU accepts instr_out this cycle.
- jump_target  input  DATA_W  CPU reg0 value; ADDR_W LSBs are the branch destination.
- cond_value  input  DATA_W  CPU reg3 value, tested by condition instructions (two's complement).
- pc_out  output  ADDR_W  current program counter.
- busy  output  1  high in FETCH or ISSUE.
- halted  output  1  high in HALT.
- issued_count  output  CNT_W  number of accepted instructions since the last run.

Behaviour:
- Reset (asynchronous): state=IDLE, pc_out=0, instr_out=0, instr_valid=0, busy=0, halted=0, issued_count=0, latched length=0. Memory contents are not cleared.
- Memory: 1 write port and 1 synchronous read port. A read issued in FETCH returns data on the next edge.
- IDLE/HALT:
  - load_en writes load_data to mem[load_addr].
  - On run: pc<=0, issued_count<=0, latch prog_len. If the latched length is 0, go to HALT; otherwise go to FETCH.
  - If load_en and run are asserted in the same cycle, the write completes and run is still taken.
- FETCH (exactly 1 cycle): read mem[pc]; next state ISSUE; instr_valid rises on entry to ISSUE.
  - Fetch latency is 1 clock from PC update to valid.
- ISSUE:
  - instr_out stays stable and instr_valid stays high until instr_ready is sampled high. The CPU may stall indefinitely.
  - On accept: instr_valid<=0 and issued_count increments, saturating at all-ones.
- Branch resolution on the accept edge, when instr[7:6]==2'b11:
  - instr[2:0] selects the test on signed cond_value: 000 never; 001 ==0; 010 <0; 011 <=0; 100 always; 101 !=0; 110 >=0; 111 >0.
  - Taken: next_pc=jump_target[ADDR_W-1:0]. Otherwise next_pc=pc+1, wrapping modulo 2**ADDR_W.
  - cond_value and jump_target are sampled only on the accept edge.
- After accept:
  - If the branch is not taken and pc+1 >= latched length (compared at ADDR_W+1 bits, no wrap), go to HALT with pc unchanged.
  - Otherwise pc<=next_pc and go to FETCH.
  - A taken branch never halts, even when the target is >= length; that target is then fetched.
- Throughput: at most 1 instruction per 2 cycles (FETCH+ISSUE). This is intentional; no prefetch.
- load_en in FETCH/ISSUE is ignored, with no memory write. run in FETCH/ISSUE is ignored.
- Reset asserted mid-ISSUE drops instr_valid immediately (asynchronously) and discards the pending instruction.
- Outputs: busy and halted are registered decodes of state. pc_out reflects the registered pc.

Decomposition:
- Shared package (cpu_pkg):
  - opcode localparams: OP_IMM=2'b00, OP_CALC=2'b01, OP_COPY=2'b10, OP_COND=2'b11;
  - condition-code encodings COND_NEVER..COND_GT;
  - fetch-state enum {IDLE, FETCH, ISSUE, HALT}.
- One sub-module, prog_mem: single write port, synchronous read, ADDR_W/DATA_W parameterised.
- The condition evaluator is a package function, cond_eval(code, value), so that `main` can reuse it.

Test Plan:
- Load 8'h8D, 8'h00, 8'h30, 8'h12, 8'h82 at addresses 0-4; prog_len=5; run; instr_ready held at 1 → these five values are issued in order, each valid for exactly 1 cycle, 2 cycles apart; then halted=1, pc_out=4, issued_count=5.
- Same program with instr_ready low for 7 cycles at address 2 → instr_out holds 8'h30 with valid high for all 8 cycles; no skip or duplicate; final issued_count=5.
- Branches:
  - mem[1]=8'hC4 (always), jump_target=8'h00, prog_len=3 → addresses cycle 0,1,0,1… and never halt.
  - mem[1]=8'hC1 (==0) with cond_value=8'h05 → not taken; addresses 0,1,2, then HALT.
- Signed tests on mem[0]=8'hC2 (<0):
  - cond_value=8'h80 → taken to jump_target=8'h04;
  - cond_value=8'h7F → not taken, next pc=1.
- Edge cases:
  - prog_len=0 with run → HALT next cycle, issued_count=0, instr_valid never rises.
  - prog_len=256 → pc wraps only on branch; no-branch run halts after address 255 with issued_count=256.
- Assert rst while in ISSUE with valid high → instr_valid=0 immediately; state=IDLE, pc_out=0; memory contents are preserved, and a rerun reissues 8'h8D first.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU and its instruction fetch unit:
// opcode and condition encodings, fetch states, and the branch condition test.
package cpu_pkg;

  localparam logic [1:0] OP_IMM  = 2'b00;
  localparam logic [1:0] OP_CALC = 2'b01;
  localparam logic [1:0] OP_COPY = 2'b10;
  localparam logic [1:0] OP_COND = 2'b11;

  localparam logic [2:0] COND_NEVER  = 3'b000;
  localparam logic [2:0] COND_EQ     = 3'b001;
  localparam logic [2:0] COND_LT     = 3'b010;
  localparam logic [2:0] COND_LE     = 3'b011;
  localparam logic [2:0] COND_ALWAYS = 3'b100;
  localparam logic [2:0] COND_NE     = 3'b101;
  localparam logic [2:0] COND_GE     = 3'b110;
  localparam logic [2:0] COND_GT     = 3'b111;

  typedef enum logic [1:0] {IDLE, FETCH, ISSUE, HALT} fetch_state_t;

  // value is a two's complement CPU register; sign is its MSB.
  function automatic logic cond_eval(input logic [2:0] code, input logic [7:0] value);
    logic zero;
    logic neg;
    logic result;
    zero = (value == 8'd0);
    neg  = value[7];
    case (code)
      COND_NEVER:  result = 1'b0;
      COND_EQ:     result = zero;
      COND_LT:     result = neg;
      COND_LE:     result = neg | zero;
      COND_ALWAYS: result = 1'b1;
      COND_NE:     result = ~zero;
      COND_GE:     result = ~neg;
      COND_GT:     result = ~neg & ~zero;
      default:     result = 1'b0;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/prog_mem.sv
// Program memory: one write port and one registered read port, maps onto block RAM.
module prog_mem #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // rd_data holds its value between reads, which keeps the issued word stable.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction source for the CPU: loadable program memory, program counter,
// valid/ready issue and branch resolution on condition-class instructions.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic [ADDR_W:0]   prog_len,
  input  logic              run,
  output logic [DATA_W-1:0] instr_out,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic [DATA_W-1:0] jump_target,
  input  logic [DATA_W-1:0] cond_value,
  output logic [ADDR_W-1:0] pc_out,
  output logic              busy,
  output logic              halted,
  output logic [CNT_W-1:0]  issued_count
);

  fetch_state_t      state_reg, state_next;
  logic [ADDR_W-1:0] pc_reg, pc_next;
  logic [ADDR_W:0]   len_reg;
  logic              valid_reg;
  logic              busy_reg;
  logic              halted_reg;
  logic [CNT_W-1:0]  count_reg;
  logic [DATA_W-1:0] mem_rd_data;

  logic              idle_like;
  logic              run_take;
  logic              accept;
  logic              taken;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W:0]   pc_inc_wide;

  assign idle_like   = (state_reg == IDLE) || (state_reg == HALT);
  assign run_take    = idle_like && run;
  assign accept      = (state_reg == ISSUE) && valid_reg && instr_ready;
  assign taken       = (mem_rd_data[DATA_W-1 -: 2] == OP_COND) &&
                       cond_eval(mem_rd_data[2:0], cond_value);
  assign pc_inc      = pc_reg + 1'b1;
  assign pc_inc_wide = {1'b0, pc_reg} + {{ADDR_W{1'b0}}, 1'b1};

  prog_mem #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_prog_mem (
    .clk     (clk),
    .wr_en   (idle_like && load_en),
    .wr_addr (load_addr),
    .wr_data (load_data),
    .rd_en   (state_reg == FETCH),
    .rd_addr (pc_reg),
    .rd_data (mem_rd_data)
  );

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    case (state_reg)
      IDLE, HALT: begin
        if (run) begin
          pc_next    = '0;
          state_next = (prog_len == '0) ? HALT : FETCH;
        end
      end
      FETCH: state_next = ISSUE;
      ISSUE: begin
        if (accept) begin
          // Falling off the end halts with pc left on the last word; a taken branch never halts.
          if (!taken && (pc_inc_wide >= len_reg)) begin
            state_next = HALT;
          end else begin
            pc_next    = taken ? jump_target[ADDR_W-1:0] : pc_inc;
            state_next = FETCH;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      pc_reg     <= '0;
      len_reg    <= '0;
      valid_reg  <= 1'b0;
      busy_reg   <= 1'b0;
      halted_reg <= 1'b0;
      count_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      pc_reg     <= pc_next;
      valid_reg  <= (state_next == ISSUE);
      busy_reg   <= (state_next == FETCH) || (state_next == ISSUE);
      halted_reg <= (state_next == HALT);
      if (run_take) len_reg <= prog_len;
      if (run_take)
        count_reg <= '0;
      else if (accept && (count_reg != '1))
        count_reg <= count_reg + 1'b1;
    end
  end

  // The memory output has no reset, so the word is gated by valid to read zero after reset.
  assign instr_out    = valid_reg ? mem_rd_data : '0;
  assign instr_valid  = valid_reg;
  assign pc_out       = pc_reg;
  assign busy         = busy_reg;
  assign halted       = halted_reg;
  assign issued_count = count_reg;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus random
// programs, checked against a transaction-level model of the fetch/branch rules.
module tb_instr_fetch_unit;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              load_en;
  logic [ADDR_W-1:0] load_addr;
  logic [DATA_W-1:0] load_data;
  logic [ADDR_W:0]   prog_len;
  logic              run;
  logic [DATA_W-1:0] instr_out;
  logic              instr_valid;
  logic              instr_ready;
  logic [DATA_W-1:0] jump_target;
  logic [DATA_W-1:0] cond_value;
  logic [ADDR_W-1:0] pc_out;
  logic              busy;
  logic              halted;
  logic [CNT_W-1:0]  issued_count;

  always #5 clk = ~clk;

  instr_fetch_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .load_en      (load_en),
    .load_addr    (load_addr),
    .load_data    (load_data),
    .prog_len     (prog_len),
    .run          (run),
    .instr_out    (instr_out),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .jump_target  (jump_target),
    .cond_value   (cond_value),
    .pc_out       (pc_out),
    .busy         (busy),
    .halted       (halted),
    .issued_count (issued_count)
  );

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  logic [7:0] model_mem [256];
  int         model_pc;
  int         model_len;
  int         model_cnt;
  bit         model_halt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit ref_taken(input logic [7:0] instr, input logic [7:0] cv);
    int v;
    v = $signed(cv);
    if (instr[7:6] != 2'b11) return 1'b0;
    case (instr[2:0])
      3'd0: return 1'b0;
      3'd1: return v == 0;
      3'd2: return v < 0;
      3'd3: return v <= 0;
      3'd4: return 1'b1;
      3'd5: return v != 0;
      3'd6: return v >= 0;
      default: return v > 0;
    endcase
  endfunction

  task automatic model_accept(input logic [7:0] cv, input logic [7:0] jt);
    bit t;
    t = ref_taken(model_mem[model_pc], cv);
    if (model_cnt < 65535) model_cnt++;
    if (!t && (model_pc + 1 >= model_len)) model_halt = 1'b1;
    else model_pc = t ? int'(jt) : (model_pc + 1) % 256;
  endtask

  task automatic load_word(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    load_en = 1'b1; load_addr = a; load_data = d;
    @(posedge clk); #1;
    load_en = 1'b0;
    model_mem[a] = d;
  endtask

  task automatic start(input int len);
    @(negedge clk);
    prog_len = 9'(len); run = 1'b1;
    @(posedge clk); #1;
    run = 1'b0;
    model_pc = 0; model_cnt = 0; model_len = len; model_halt = (len == 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; instr_ready = 1'b1;
  endtask

  // Drives ready high except for an optional stall at stall_addr, and checks every issued word.
  task automatic run_loop(input int max_acc, input int stall_addr, input int stall_n,
                          input int cv_fix, input int jt_fix, input int jt_max, input bit gap_chk);
    int cyc = 0;
    int last = -1;
    int acc = 0;
    int stall_left = stall_n;
    bit post = 1'b0;
    logic [7:0] cv, jt;
    forever begin
      @(negedge clk); cyc++;
      if (cyc > 3000) begin
        checks++; fails++;
        $error("FAIL timeout: got %0d cycles expected halt or %0d accepts", cyc, max_acc);
        break;
      end
      if (post) begin
        chk("valid_after_accept", 32'(instr_valid), 32'd0);
        chk("halted_after_accept", 32'(halted), 32'(model_halt));
        chk("count_after_accept", 32'(issued_count), 32'(model_cnt));
        post = 1'b0;
        if (model_halt || acc >= max_acc) break;
      end else if (instr_valid) begin
        $display("issue #%0d addr=%0d instr=%02h", acc, pc_out, instr_out);
        chk("instr", 32'(instr_out), 32'(model_mem[model_pc]));
        chk("pc", 32'(pc_out), 32'(model_pc));
        if (gap_chk && last >= 0) chk("issue_gap", 32'(cyc - last), 32'd2);
        last = cyc;
        if (model_pc == stall_addr && stall_left > 0) begin
          instr_ready = 1'b0;
          load_en = 1'b1; load_addr = 8'd3; load_data = 8'hFF; run = 1'b1;
          repeat (stall_left) begin
            @(negedge clk); cyc++;
            chk("stall_valid", 32'(instr_valid), 32'd1);
            chk("stall_instr", 32'(instr_out), 32'(model_mem[model_pc]));
          end
          stall_left = 0;
          instr_ready = 1'b1; load_en = 1'b0; run = 1'b0;
        end
        cv = (cv_fix < 0) ? 8'($urandom) : 8'(cv_fix);
        jt = (jt_fix < 0) ? 8'($urandom_range(0, jt_max)) : 8'(jt_fix);
        cond_value = cv; jump_target = jt;
        model_accept(cv, jt);
        acc++;
        post = 1'b1;
      end
    end
  endtask

  initial begin
    int len;
    int waited;
    rst = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0; prog_len = '0;
    run = 1'b0; instr_ready = 1'b1; jump_target = '0; cond_value = '0;

    @(negedge clk);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", 32'(instr_out), 32'd0);
    chk("rst_pc", 32'(pc_out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_count", 32'(issued_count), 32'd0);
    rst = 1'b0;

    // Known non-branch contents everywhere so any fetch address has a model value.
    for (int a = 0; a < 256; a++) load_word(8'(a), 8'($urandom_range(0, 191)));

    // Straight-line program with ready held high.
    load_word(8'd0, 8'h8D); load_word(8'd1, 8'h00); load_word(8'd2, 8'h30);
    load_word(8'd3, 8'h12); load_word(8'd4, 8'h82);
    start(5);
    run_loop(100, -1, 0, -1, -1, 255, 1'b1);
    chk("t1_halted", 32'(halted), 32'd1);
    chk("t1_busy", 32'(busy), 32'd0);
    chk("t1_pc", 32'(pc_out), 32'd4);
    chk("t1_count", 32'(issued_count), 32'd5);

    // Stall at address 2 for 7 cycles; load and run during the stall must be ignored.
    start(5);
    run_loop(100, 2, 7, -1, -1, 255, 1'b0);
    chk("t2_count", 32'(issued_count), 32'd5);

    // Unconditional branch back to 0 loops forever.
    load_word(8'd1, 8'hC4);
    start(3);
    run_loop(9, -1, 0, -1, 0, 0, 1'b1);
    do_reset();

    // ==0 with a nonzero value is not taken.
    load_word(8'd1, 8'hC1);
    start(3);
    run_loop(100, -1, 0, 8'h05, 0, 0, 1'b1);
    chk("t4_pc", 32'(pc_out), 32'd2);

    // Signed <0 test.
    load_word(8'd1, 8'h00); load_word(8'd0, 8'hC2);
    start(5);
    run_loop(100, -1, 0, 8'h80, 4, 4, 1'b1);
    chk("t5_pc", 32'(pc_out), 32'd4);
    chk("t5_count", 32'(issued_count), 32'd2);
    start(5);
    run_loop(100, -1, 0, 8'h7F, 4, 4, 1'b1);
    chk("t6_count", 32'(issued_count), 32'd5);

    // Zero-length program.
    start(0);
    @(negedge clk);
    chk("t7_halted", 32'(halted), 32'd1);
    chk("t7_count", 32'(issued_count), 32'd0);
    repeat (4) begin
      chk("t7_valid", 32'(instr_valid), 32'd0);
      @(negedge clk);
    end

    // Full-depth program: halts after address 255 without wrapping.
    load_word(8'd0, 8'h8D);
    start(256);
    run_loop(300, -1, 0, -1, -1, 255, 1'b1);
    chk("t8_pc", 32'(pc_out), 32'd255);
    chk("t8_count", 32'(issued_count), 32'd256);

    // Wrap only via a branch at the last address.
    load_word(8'd255, 8'hC4);
    start(256);
    run_loop(258, -1, 0, -1, 0, 0, 1'b1);
    do_reset();
    load_word(8'd255, 8'h00);

    // Random programs with mixed condition instructions.
    repeat (3) begin
      len = $urandom_range(2, 12);
      for (int a = 0; a < len; a++) begin
        if ($urandom_range(0, 9) < 3) load_word(8'(a), {2'b11, 3'($urandom), 3'($urandom)});
        else load_word(8'(a), 8'($urandom_range(0, 191)));
      end
      start(len);
      run_loop(40, -1, 0, -1, -1, len + 2, 1'b1);
      do_reset();
    end

    // Reset in the middle of an issue; memory must survive.
    load_word(8'd0, 8'h8D); load_word(8'd1, 8'h00); load_word(8'd2, 8'h30);
    load_word(8'd3, 8'h12); load_word(8'd4, 8'h82);
    start(5);
    waited = 0;
    @(negedge clk);
    while (!instr_valid && waited < 10) begin
      @(negedge clk); waited++;
    end
    chk("t11_valid_seen", 32'(instr_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("t11_valid", 32'(instr_valid), 32'd0);
    chk("t11_instr", 32'(instr_out), 32'd0);
    chk("t11_pc", 32'(pc_out), 32'd0);
    chk("t11_busy", 32'(busy), 32'd0);
    chk("t11_count", 32'(issued_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    start(5);
    run_loop(100, -1, 0, -1, -1, 255, 1'b1);
    chk("t11_rerun_count", 32'(issued_count), 32'd5);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
